// File: rtl/mod_mem_access_unit.sv
// Single-outstanding load/store unit: byte enables, word-aligned req/gnt bus access, load extension, timeout.
// Define MEM_MISALIGNED_TRAP_EN to fault misaligned halfword/word accesses without touching the bus.

`ifndef XLEN
`define XLEN 32
`endif
`ifndef FUNCT3_WIDTH
`define FUNCT3_WIDTH 3
`endif
`ifndef FUNCT3_LB
`define FUNCT3_LB 3'b000
`endif
`ifndef FUNCT3_LH
`define FUNCT3_LH 3'b001
`endif
`ifndef FUNCT3_LW
`define FUNCT3_LW 3'b010
`endif
`ifndef FUNCT3_LBU
`define FUNCT3_LBU 3'b100
`endif
`ifndef FUNCT3_LHU
`define FUNCT3_LHU 3'b101
`endif
`ifndef FUNCT3_SB
`define FUNCT3_SB 3'b000
`endif
`ifndef FUNCT3_SH
`define FUNCT3_SH 3'b001
`endif
`ifndef FUNCT3_SW
`define FUNCT3_SW 3'b010
`endif

module mod_mem_access_unit #(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   input  logic                     req_valid_i,
   output logic                     req_ready_o,
   input  logic                     req_we_i,
   input  logic [`FUNCT3_WIDTH-1:0] funct3_i,
   input  logic [`XLEN-1:0]         addr_i,
   input  logic [`XLEN-1:0]         wdata_i,
   output logic                     rsp_valid_o,
   output logic [`XLEN-1:0]         rsp_rdata_o,
   output logic                     rsp_fault_o,
   output logic                     rsp_misaligned_o,
   output logic                     bus_req_o,
   output logic                     bus_we_o,
   output logic [`XLEN-1:0]         bus_addr_o,
   output logic [`XLEN-1:0]         bus_wdata_o,
   output logic [3:0]               bus_be_o,
   input  logic                     bus_gnt_i,
   input  logic                     bus_rvalid_i,
   input  logic [`XLEN-1:0]         bus_rdata_i
);

`ifdef MEM_MISALIGNED_TRAP_EN
   localparam bit TRAP_EN = 1'b1;
`else
   localparam bit TRAP_EN = 1'b0;
`endif

   localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES);
   // The access times out in the cycle where the counter would step onto TIMEOUT_CYCLES-1.
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 2);

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RESP} state_t;

   state_t                    state_q, state_d;
   logic                      we_q;
   logic [`FUNCT3_WIDTH-1:0]  funct3_q;
   logic [1:0]                off_q;
   logic [`XLEN-1:0]          addr_q;
   logic [`XLEN-1:0]          wdata_q;
   logic [3:0]                be_q;
   logic [CNT_W-1:0]          cnt_q;
   logic [`XLEN-1:0]          rdata_q;
   logic                      fault_q;
   logic                      misaligned_q;

   logic                      acc_legal;
   logic                      acc_misaligned;
   logic [3:0]                be_dec;
   logic                      timeout;

   function automatic logic [`XLEN-1:0] extract(input logic [`FUNCT3_WIDTH-1:0] f3,
                                                 input logic [1:0] off,
                                                 input logic [`XLEN-1:0] word);
      logic [7:0]  b;
      logic [15:0] h;
      b = word[{off, 3'b000} +: 8];
      h = (off != 2'b00) ? word[31:16] : word[15:0];
      case (f3)
         `FUNCT3_LB:  extract = {{(`XLEN-8){b[7]}}, b};
         `FUNCT3_LH:  extract = {{(`XLEN-16){h[15]}}, h};
         `FUNCT3_LBU: extract = {{(`XLEN-8){1'b0}}, b};
         `FUNCT3_LHU: extract = {{(`XLEN-16){1'b0}}, h};
         default:     extract = word;
      endcase
   endfunction

   // NOTE: every signal driven in always_comb gets a default first, so no path can infer a latch.
   always_comb begin
      acc_legal      = 1'b0;
      be_dec         = 4'b1111;
      // Store encodings SB/SH/SW coincide with LB/LH/LW.
      case (funct3_i)
         `FUNCT3_LB, `FUNCT3_LH, `FUNCT3_LW: acc_legal = 1'b1;
         `FUNCT3_LBU, `FUNCT3_LHU:           acc_legal = !req_we_i;
         default:                            acc_legal = 1'b0;
      endcase
      case (funct3_i[1:0])
         2'b00:   be_dec = 4'b0001 << addr_i[1:0];
         2'b01:   be_dec = (addr_i[1:0] != 2'b00) ? 4'b1100 : 4'b0011;
         default: be_dec = 4'b1111;
      endcase
      acc_misaligned = TRAP_EN &&
                       (((funct3_i[1:0] == 2'b01) && addr_i[0]) ||
                        ((funct3_i[1:0] == 2'b10) && (addr_i[1:0] != 2'b00)));
   end

   assign timeout = (cnt_q >= CNT_LAST);

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: if (req_valid_i) state_d = (!acc_legal || acc_misaligned) ? S_RESP : S_REQ;
         S_REQ:  if (bus_gnt_i || timeout) state_d = bus_gnt_i ? S_WAIT : S_RESP;
         S_WAIT: if (bus_rvalid_i || timeout) state_d = S_RESP;
         S_RESP: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q      <= S_IDLE;
         we_q         <= 1'b0;
         funct3_q     <= '0;
         off_q        <= '0;
         addr_q       <= '0;
         wdata_q      <= '0;
         be_q         <= '0;
         cnt_q        <= '0;
         rdata_q      <= '0;
         fault_q      <= 1'b0;
         misaligned_q <= 1'b0;
      end else begin
         state_q <= state_d;
         case (state_q)
            S_IDLE: if (req_valid_i) begin
               we_q         <= req_we_i;
               funct3_q     <= funct3_i;
               off_q        <= addr_i[1:0];
               addr_q       <= {addr_i[`XLEN-1:2], 2'b00};
               wdata_q      <= wdata_i;
               be_q         <= be_dec;
               cnt_q        <= '0;
               rdata_q      <= '0;
               fault_q      <= !acc_legal || acc_misaligned;
               misaligned_q <= acc_legal && acc_misaligned;
            end
            S_REQ: begin
               if (!bus_gnt_i && timeout) fault_q <= 1'b1;
               if (state_d != S_RESP) cnt_q <= cnt_q + CNT_W'(1);
            end
            S_WAIT: begin
               if (bus_rvalid_i) begin
                  if (!we_q) rdata_q <= extract(funct3_q, off_q, bus_rdata_i);
               end else if (timeout) begin
                  fault_q <= 1'b1;
               end
               if (state_d != S_RESP) cnt_q <= cnt_q + CNT_W'(1);
            end
            default: ;
         endcase
      end
   end

   assign req_ready_o      = (state_q == S_IDLE);
   assign bus_req_o        = (state_q == S_REQ);
   assign rsp_valid_o      = (state_q == S_RESP);
   assign rsp_rdata_o      = rdata_q;
   assign rsp_fault_o      = fault_q;
   assign rsp_misaligned_o = TRAP_EN ? misaligned_q : 1'b0;
   assign bus_we_o         = we_q;
   assign bus_addr_o       = addr_q;
   assign bus_wdata_o      = wdata_q;
   assign bus_be_o         = be_q;

endmodule

// File: doc/mod_mem_access_unit.md
# mod_mem_access_unit

Memory access unit between the execute stage's store data aligner and the data memory bus. It accepts one load or store per handshake, with store data already placed in the correct byte lanes. It derives byte enables and issues a word-aligned request/grant bus transaction, then returns a sign- or zero-extended load result or a fault to the pipeline. It is single-outstanding: while busy, `req_ready_o` is low and the pipeline stalls.

## Interface
- TIMEOUT_CYCLES, 255: maximum cycles spent in REQ plus WAIT before the access is aborted with a fault; minimum 2.
- clk_i  in  1  single clock, all state updates on rising edge.
- rst_ni  in  1  synchronous, active-low reset.
- req_valid_i  in  1  pipeline presents an access.
- req_ready_o  out  1  unit idle; accepts when `req_valid_i & req_ready_o`.
- req_we_i  in  1  1 = store, 0 = load.
- funct3_i  in  `FUNCT3_WIDTH  access size and sign (`FUNCT3_SB/SH/SW`, LB/LH/LW/LBU/LHU encodings).
- addr_i  in  `XLEN  unaligned byte address.
- wdata_i  in  `XLEN  lane-aligned store data from the store aligner.
- rsp_valid_o  out  1  one-cycle completion pulse; no backpressure.
- rsp_rdata_o  out  `XLEN  extended load data; 0 for stores and faults.
- rsp_fault_o  out  1  access fault (timeout, illegal funct3, misaligned).
- rsp_misaligned_o  out  1  fault cause is misalignment.
- bus_req_o  out  1  bus request, held until granted.
- bus_we_o  out  1  bus write.
- bus_addr_o  out  `XLEN  `addr & ~3`.
- bus_wdata_o  out  `XLEN  registered `wdata_i`.
- bus_be_o  out  4  byte enables.
- bus_gnt_i  in  1  grant; sampled only in REQ.
- bus_rvalid_i  in  1  read data / write acknowledge; sampled only in WAIT.
- bus_rdata_i  in  `XLEN  full read word.

## Operation
- States: IDLE, REQ, WAIT, RESP.
- IDLE: `req_ready_o=1`. On accept, register we, funct3, addr, wdata and clear the timeout counter.
  - Illegal funct3 for the direction → RESP with fault.
  - Misaligned (when enabled) → RESP with fault and misaligned.
  - Otherwise → REQ.
- REQ: `bus_req_o=1` with stable address, we, wdata and be. On `bus_gnt_i` → WAIT.
- WAIT: on `bus_rvalid_i` → RESP; for loads, capture the extracted data.
- RESP: `rsp_valid_o=1` for exactly one cycle → IDLE.
- Timeout: counter increments each cycle in REQ or WAIT. On reaching TIMEOUT_CYCLES-1 without progress → RESP with `rsp_fault_o=1`, rdata 0, bus_req dropped.
- Byte offset is `addr[1:0]`.
- Byte enables:
  - SB: `4'b0001 << off`.
  - SH: 4'b1100 if off≠0, else 4'b0011. This matches the aligner's half placement.
  - SW: 4'b1111.
- Load extract: the same lane selection as byte enables.
  - LB/LH sign-extend from bit 7/15 of the selected lane.
  - LBU/LHU zero-extend.
  - LW passes the full word.
- Stores always complete with rdata 0; a store acknowledge still requires `bus_rvalid_i`.
- A `bus_rvalid_i` outside WAIT, or a `bus_gnt_i` outside REQ, is ignored.

## Timing
- Reset values: state IDLE; `req_ready_o=1`; `rsp_valid_o`, `rsp_fault_o`, `rsp_misaligned_o`, `bus_req_o`, `bus_we_o` = 0; `rsp_rdata_o`, `bus_addr_o`, `bus_wdata_o` = 0; `bus_be_o` = 0; counter 0.
- Minimum latency: accept at edge 0, `bus_req_o` high in cycle 1.
  - Grant in cycle 1 → WAIT in cycle 2.
  - rvalid in cycle 2 → `rsp_valid_o` in cycle 3.
  - New accept possible at edge 4.
- Fault without bus access (illegal/misaligned): `rsp_valid_o` in cycle 1.
- All outputs are registered or decoded from registered state; there is no combinational path from req_* to bus_*.
- Reset asserted mid-transaction: IDLE at the next edge, `bus_req_o` low, pending response discarded, late `bus_rvalid_i` ignored.

## Configuration
- `MEM_MISALIGNED_TRAP_EN` defined: these accesses produce no bus transaction, and RESP follows with fault=1 and misaligned=1:
  - SH/LH/LHU with `addr[0]=1`.
  - SW/LW with `addr[1:0]≠0`.
- Undefined: `rsp_misaligned_o` is tied 0. Misaligned accesses proceed using the lane rules above; low address bits are truncated, with no fault.

## Test plan
- LB at addr 0x103, bus word 0x80_12_34_56: be 4'b1000, addr 0x100, rsp_rdata 0xFFFFFF80, `rsp_valid_o` exactly cycle 3 with immediate gnt/rvalid.
- SH at 0x202, wdata 0xBEEF0000: bus_be 4'b1100, bus_addr 0x200, bus_we 1; response rdata 0, fault 0. Repeat with LHU at 0x202 on word 0xBEEF1234 → rdata 0x0000BEEF.
- Grant withheld 4 cycles: bus_req held with stable addr/be; `req_ready_o` low throughout; response follows the rvalid.
- No rvalid, TIMEOUT_CYCLES=8: fault pulse 8 cycles after accept, bus_req low, unit accepts again.
- LW at 0x101: with `MEM_MISALIGNED_TRAP_EN`, no bus_req, response in cycle 1 with fault=1, misaligned=1. Without the macro, bus_addr 0x100, be 4'b1111, fault 0.
- Reset driven low while in WAIT, then rvalid pulses: no `rsp_valid_o`, state IDLE, `req_ready_o=1`.
